xor_stream_decrypt: RTL and testbench
=====================================

// Module: xor_stream_decrypt
// PURPOSE
//  Receive end of the serial XOR cipher link: accepts a serial key, then serial
//  ciphertext bits, and XORs each bit with the cyclically repeating key.
//  Emits the plaintext both serially and as a parallel word with a valid pulse.
//  Sits downstream of the XOR encrypt top and recovers the original message.
// PARAMETERS
//  KEY_W  4  key length in bits; key is reused cyclically across the message
//  MSG_W  8  bits per output word; sets oMsg width and the word-complete count
// PORTS
//  iClk       in   1      system clock; all logic on rising edge
//  iRst       in   1      synchronous, active-high reset
//  iEn        in   1      global enable; when 0 all state holds, outputs hold
//  iData_in   in   1      serial input bit: key bit or ciphertext bit
//  iLoad_key  in   1      high: iData_in carries key bits, MSB first
//  iLoad_msg  in   1      high: iData_in carries ciphertext bits, MSB first
//  oData_out  out  1      serial plaintext bit, registered
//  oBit_vld   out  1      oData_out is valid this cycle
//  oMsg       out  MSG_W  last complete plaintext word, MSB = first bit received
//  oValid     out  1      one-cycle pulse: oMsg updated
//  oKey_rdy   out  1      full KEY_W-bit key is held
//  oErr       out  1      one-cycle pulse: protocol violation
// BEHAVIOUR
//  Reset: every output 0; key, shift reg and all counters 0; FSM -> IDLE.
//  All actions below qualify on iEn=1; with iEn=0 nothing changes and the
//   pulse outputs (oBit_vld, oValid, oErr) drop to 0.
//  FSM states: IDLE, LOAD_KEY, RECV_MSG.
//   IDLE->LOAD_KEY on iLoad_key; IDLE->RECV_MSG on iLoad_msg & oKey_rdy.
//   LOAD_KEY->IDLE when iLoad_key falls. RECV_MSG->IDLE when iLoad_msg falls.
//  Key load: each cycle in LOAD_KEY, key <= {key[KEY_W-2:0], iData_in}.
//   key_cnt saturates at KEY_W; oKey_rdy = (key_cnt==KEY_W).
//   Entering LOAD_KEY clears key_cnt, so oKey_rdy=0 until KEY_W new bits.
//   More than KEY_W bits: the last KEY_W bits are kept.
//  Decrypt: each cycle in RECV_MSG, p = iData_in ^ key[KEY_W-1-kidx].
//   kidx wraps KEY_W-1 -> 0. The next cycle gives oData_out=p, oBit_vld=1.
//   p shifts into sreg; bcnt increments.
//  Word done: on the cycle the MSG_W-th bit is sampled, oMsg <= completed sreg
//   and oValid=1 on the next cycle (1-cycle latency). bcnt wraps to 0.
//   kidx continues; it does not restart per word.
//  kidx and bcnt clear on every RECV_MSG entry, matching the encryptor restart.
//  iLoad_msg falls mid-word: the partial word is discarded, oMsg holds, no oValid.
//  iLoad_msg while oKey_rdy=0: bits ignored, oErr pulses each such cycle.
//  iLoad_key & iLoad_msg together: key load wins, cipher bit ignored, oErr pulses.
//   In RECV_MSG this forces LOAD_KEY and drops the partial word.
//  iRst mid-operation: immediate return to reset state; the key is lost.
// STRUCTURE
//  Shared include xor_defs.vh: KEY_W/MSG_W defaults and FSM state encodings
//   (common with the encrypt side).
//  Sub-module xor_key_reg: key shift register, key_cnt, kidx and cyclic key-bit
//   select (reused by the encryptor). The FSM, sreg and bcnt stay in this module.
// TESTING
//  1 Reset: iRst=1 for 2 cycles -> all outputs 0, oKey_rdy=0.
//  2 Key 1011 MSB first, then cipher 0,0,1,1,0,0,1,0 (0x32) -> oData_out stream
//    1,0,0,0,1,0,0,1; oMsg=0x89 with oValid 1 cycle after the 8th bit.
//  3 16 cipher bits 0x32,0x32 back to back -> oValid twice; second oMsg=0x89
//    (kidx continuity, KEY_W divides MSG_W).
//  4 KEY_W=3 build: key 101, cipher 0x00 then 0x00 -> oMsg=0xB6 then 0xDB
//    (key phase carries across words).
//  5 Cipher before any key -> oErr pulses per bit, oValid never asserts.
//    Drop iLoad_msg after 5 bits -> oMsg unchanged.
//  6 iLoad_key & iLoad_msg both high mid-word -> oErr, state LOAD_KEY, oKey_rdy=0.
//    iEn=0 for 3 cycles mid-word -> resumes; 0x89 is still recovered.

Source files
------------

// File: rtl/xor_stream_decrypt_pkg.sv
// Shared defaults and FSM encoding for the serial XOR cipher receive path.
package xor_stream_decrypt_pkg;

    localparam int DEF_KEY_W = 4;
    localparam int DEF_MSG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_KEY = 2'd1,
        ST_RECV_MSG = 2'd2
    } xorState_e;

    // Index width that stays legal for degenerate single-entry ranges.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xor_stream_decrypt_key_reg.sv
// Key shift register with fill counter and cyclic key-bit selector.
import xor_stream_decrypt_pkg::*;

module xor_stream_decrypt_key_reg #(
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iShift,   // shift iBit into the key this cycle
    input  logic iCntClr,  // first bit of a new key load
    input  logic iBit,
    input  logic iStep,    // consume one key bit for decryption
    input  logic iIdxClr,  // first cipher bit of a new message
    output logic oKeyBit,
    output logic oKeyRdy
);

    localparam int KIDX_W = idxWidth(KEY_W);
    localparam int CNT_W  = $clog2(KEY_W + 1);
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(KEY_W);

    logic [KEY_W-1:0]  keyReg;
    logic [CNT_W-1:0]  keyCntReg;
    logic [KIDX_W-1:0] kidxReg;
    logic [KIDX_W-1:0] kidxEff;

    // A restarting message uses key bit 0 on its very first cipher bit.
    assign kidxEff = iIdxClr ? '0 : kidxReg;
    assign oKeyBit = keyReg[KIDX_LAST - kidxEff];
    assign oKeyRdy = (keyCntReg == CNT_MAX);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            keyReg    <= '0;
            keyCntReg <= '0;
            kidxReg   <= '0;
        end else begin
            if (iShift) begin
                keyReg <= {keyReg[KEY_W-2:0], iBit};
                if (iCntClr)
                    keyCntReg <= CNT_W'(1);
                else if (keyCntReg != CNT_MAX)
                    keyCntReg <= keyCntReg + CNT_W'(1);
            end
            if (iStep)
                kidxReg <= (kidxEff == KIDX_LAST) ? '0 : kidxEff + KIDX_W'(1);
        end
    end

endmodule

// File: rtl/xor_stream_decrypt.sv
// Serial XOR stream decryptor: loads a key, decrypts cipher bits, emits words.
import xor_stream_decrypt_pkg::*;

module xor_stream_decrypt #(
    parameter int KEY_W = DEF_KEY_W,
    parameter int MSG_W = DEF_MSG_W
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iData_in,
    input  logic             iLoad_key,
    input  logic             iLoad_msg,
    output logic             oData_out,
    output logic             oBit_vld,
    output logic [MSG_W-1:0] oMsg,
    output logic             oValid,
    output logic             oKey_rdy,
    output logic             oErr
);

    localparam int BCNT_W = idxWidth(MSG_W);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MSG_W - 1);

    xorState_e         stateReg;
    logic [MSG_W-1:0]  sreg;
    logic [BCNT_W-1:0] bcntReg;
    logic [BCNT_W-1:0] bcntEff;
    logic [MSG_W-1:0]  sregNext;

    logic takeKey, takeMsg, errNow, keyRestart, msgRestart;
    logic keyBit, keyRdy, plainBit;

    // Key load always wins over a simultaneous cipher request.
    always_comb begin
        takeKey    = iLoad_key;
        takeMsg    = iLoad_msg & ~iLoad_key & keyRdy;
        errNow     = iLoad_msg & (iLoad_key | ~keyRdy);
        keyRestart = takeKey & (stateReg != ST_LOAD_KEY);
        msgRestart = takeMsg & (stateReg != ST_RECV_MSG);
        plainBit   = iData_in ^ keyBit;
        bcntEff    = msgRestart ? '0 : bcntReg;
        sregNext   = {sreg[MSG_W-2:0], plainBit};
    end

    xor_stream_decrypt_key_reg #(.KEY_W(KEY_W)) uKeyReg (
        .iClk    (iClk),
        .iRst    (iRst),
        .iShift  (iEn & takeKey),
        .iCntClr (keyRestart),
        .iBit    (iData_in),
        .iStep   (iEn & takeMsg),
        .iIdxClr (msgRestart),
        .oKeyBit (keyBit),
        .oKeyRdy (keyRdy)
    );

    assign oKey_rdy = keyRdy;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg  <= ST_IDLE;
            sreg      <= '0;
            bcntReg   <= '0;
            oData_out <= 1'b0;
            oBit_vld  <= 1'b0;
            oMsg      <= '0;
            oValid    <= 1'b0;
            oErr      <= 1'b0;
        end else if (!iEn) begin
            oBit_vld <= 1'b0;
            oValid   <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            oErr     <= errNow;
            oBit_vld <= takeMsg;
            oValid   <= 1'b0;
            if (takeKey)
                stateReg <= ST_LOAD_KEY;
            else if (takeMsg)
                stateReg <= ST_RECV_MSG;
            else
                stateReg <= ST_IDLE;

            if (takeMsg) begin
                oData_out <= plainBit;
                sreg      <= sregNext;
                if (bcntEff == BCNT_LAST) begin
                    oMsg    <= sregNext;
                    oValid  <= 1'b1;
                    bcntReg <= '0;
                end else begin
                    bcntReg <= bcntEff + BCNT_W'(1);
                end
            end else begin
                // Leaving the message stream drops any partial word.
                bcntReg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Directed bench: 4-bit and 3-bit key builds driven from shared stimulus.
`timescale 1ns/1ps
module tb_xor_stream_decrypt;

    logic       iClk = 1'b0;
    logic       iRst, iEn, iData_in, iLoad_key, iLoad_msg;
    logic       oData_out, oBit_vld, oValid, oKey_rdy, oErr;
    logic [7:0] oMsg;
    logic       bData_out, bBit_vld, bValid, bKey_rdy, bErr;
    logic [7:0] bMsg;

    int checksTotal  = 0;
    int checksPassed = 0;

    always #5 iClk = ~iClk;

    xor_stream_decrypt #(.KEY_W(4), .MSG_W(8)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iData_in(iData_in),
        .iLoad_key(iLoad_key), .iLoad_msg(iLoad_msg),
        .oData_out(oData_out), .oBit_vld(oBit_vld), .oMsg(oMsg),
        .oValid(oValid), .oKey_rdy(oKey_rdy), .oErr(oErr)
    );

    xor_stream_decrypt #(.KEY_W(3), .MSG_W(8)) dutK3 (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iData_in(iData_in),
        .iLoad_key(iLoad_key), .iLoad_msg(iLoad_msg),
        .oData_out(bData_out), .oBit_vld(bBit_vld), .oMsg(bMsg),
        .oValid(bValid), .oKey_rdy(bKey_rdy), .oErr(bErr)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checksTotal++;
        if (obs === exp) checksPassed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Apply one cycle of inputs; outputs are observed 1ns after the edge.
    task automatic drive(input logic en, input logic lk, input logic lm, input logic d);
        iEn = en; iLoad_key = lk; iLoad_msg = lm; iData_in = d;
        @(posedge iClk); #1;
        $display("t=%0t en=%0b lk=%0b lm=%0b d=%0b -> out=%0b vld=%0b msg=%02h valid=%0b rdy=%0b err=%0b",
                 $time, en, lk, lm, d, oData_out, oBit_vld, oMsg, oValid, oKey_rdy, oErr);
    endtask

    task automatic doReset();
        iRst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        iRst = 1'b0;
    endtask

    task automatic loadKey4(input logic [3:0] k);
        for (int i = 3; i >= 0; i--) drive(1'b1, 1'b1, 1'b0, k[i]);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] cipher32 = 8'h32;
    logic [7:0] plain89  = 8'h89;
    logic [7:0] cipherFF = 8'hFF;
    logic [3:0] key1011  = 4'b1011;
    logic [2:0] key101   = 3'b101;
    logic [7:0] expK3 [2] = '{8'hB6, 8'hDB};
    int         validCnt;

    initial begin
        iRst = 1'b0; iEn = 1'b1; iData_in = 1'b0; iLoad_key = 1'b0; iLoad_msg = 1'b0;

        // 1: reset state
        doReset();
        checkVal("rst_data",  oData_out, 0);
        checkVal("rst_bvld",  oBit_vld, 0);
        checkVal("rst_msg",   oMsg, 0);
        checkVal("rst_valid", oValid, 0);
        checkVal("rst_keyrdy", oKey_rdy, 0);
        checkVal("rst_err",   oErr, 0);

        // 5a: cipher with no key -> errors, nothing decoded
        validCnt = 0;
        for (int i = 7; i >= 3; i--) begin
            drive(1'b1, 1'b0, 1'b1, cipher32[i]);
            checkVal($sformatf("nokey_err%0d", i), oErr, 1);
            checkVal($sformatf("nokey_bvld%0d", i), oBit_vld, 0);
            validCnt += oValid;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("nokey_errdrop", oErr, 0);
        checkVal("nokey_valids", validCnt, 0);
        checkVal("nokey_msg", oMsg, 0);

        // 2: key 1011, cipher 0x32 -> 1,0,0,0,1,0,0,1 / 0x89
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 1'b1, 1'b0, key1011[i]);
            checkVal($sformatf("keyrdy_%0d", 3 - i), oKey_rdy, (i == 0));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, 1'b0, 1'b1, cipher32[i]);
            checkVal($sformatf("pt_bit%0d", i), oData_out, plain89[i]);
            checkVal($sformatf("pt_vld%0d", i), oBit_vld, 1);
            checkVal($sformatf("pt_valid%0d", i), oValid, (i == 0));
        end
        checkVal("pt_msg", oMsg, 8'h89);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("pt_valid_pulse", oValid, 0);

        // 3: two words back to back
        validCnt = 0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 7; i >= 0; i--) begin
                drive(1'b1, 1'b0, 1'b1, cipher32[i]);
                validCnt += oValid;
            end
            checkVal($sformatf("b2b_valid_w%0d", w), oValid, 1);
            checkVal($sformatf("b2b_msg_w%0d", w), oMsg, 8'h89);
        end
        checkVal("b2b_valids", validCnt, 2);

        // 5b: drop iLoad_msg mid-word -> oMsg holds
        validCnt = 0;
        for (int i = 7; i >= 3; i--) begin
            drive(1'b1, 1'b0, 1'b1, cipherFF[i]);
            validCnt += oValid;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        validCnt += oValid;
        checkVal("partial_valids", validCnt, 0);
        checkVal("partial_msg", oMsg, 8'h89);

        // 6a: key & msg together mid-word -> error, key invalidated
        for (int i = 7; i >= 5; i--) drive(1'b1, 1'b0, 1'b1, cipherFF[i]);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checkVal("both_err", oErr, 1);
        checkVal("both_keyrdy", oKey_rdy, 0);
        checkVal("both_bvld", oBit_vld, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("both_msg", oMsg, 8'h89);

        // 6b: reload key, iEn=0 for 3 cycles mid-word
        loadKey4(key1011);
        checkVal("reload_keyrdy", oKey_rdy, 1);
        validCnt = 0;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, 1'b0, 1'b1, cipher32[i]);
            checkVal($sformatf("en_bit%0d", i), oData_out, plain89[i]);
            if (i == 4) begin
                for (int s = 0; s < 3; s++) begin
                    drive(1'b0, 1'b0, 1'b1, s[0]);
                    checkVal($sformatf("en_hold_vld%0d", s), oBit_vld, 0);
                    validCnt += oValid;
                end
            end
        end
        checkVal("en_valid", oValid, 1);
        checkVal("en_hold_valids", validCnt, 0);
        checkVal("en_msg", oMsg, 8'h89);

        // 4: KEY_W=3 instance, key 101, cipher 0x00 twice
        doReset();
        for (int i = 2; i >= 0; i--) drive(1'b1, 1'b1, 1'b0, key101[i]);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("k3_keyrdy", bKey_rdy, 1);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
            checkVal($sformatf("k3_valid_w%0d", w), bValid, 1);
            checkVal($sformatf("k3_msg_w%0d", w), bMsg, expK3[w]);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
